// File: rtl/rvj1_mem_pkg.sv
// Shared memory-side types for the rvj1 core: RAM owner tag and default sizes.
package rvj1_mem_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/rvj1_arb_pick.sv
// Two-way grant selector; gnt = {data, fetch}, one-hot or zero.
// RVJ1_ARB_RR_EN selects round-robin instead of data priority with starvation guard.
module rvj1_arb_pick (
    input  logic       if_req,
    input  logic       d_req,
    input  logic       wait_sat,
    input  logic       rr_d,
    output logic [1:0] gnt
);

`ifdef RVJ1_ARB_RR_EN
    logic unused_sat;
    assign unused_sat = wait_sat;
`else
    logic unused_rr;
    assign unused_rr = rr_d;
`endif

    always_comb begin
        gnt = {d_req, if_req};
        if (if_req && d_req) begin
`ifdef RVJ1_ARB_RR_EN
            // Pointer holds the last winner; the other side goes next.
            gnt = rr_d ? 2'b01 : 2'b10;
`else
            gnt = wait_sat ? 2'b01 : 2'b10;
`endif
        end
    end

endmodule

// File: rtl/rvj1_ram_arbiter.sv
// Shares one single-port sync RAM between fetch and load/store ports.
// Build option RVJ1_ARB_RR_EN: round-robin arbitration, no wait counter.
module rvj1_ram_arbiter
    import rvj1_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0]        pick;
    logic              wait_sat;
    logic              rr_d;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] d_hold;

    rvj1_arb_pick u_pick (
        .if_req   (if_req),
        .d_req    (d_req),
        .wait_sat (wait_sat),
        .rr_d     (rr_d),
        .gnt      (pick)
    );

    assign if_gnt = pick[0] & ~rst;
    assign d_gnt  = pick[1] & ~rst;

    // Idle cycles keep the last address so the RAM port does not toggle.
    assign ram_we   = d_gnt & d_we;
    assign ram_di   = d_wdata;
    assign ram_addr = d_gnt  ? d_addr :
                      if_gnt ? if_addr : addr_q;

    assign if_rvalid = (owner == OWN_IF);
    assign d_rvalid  = (owner == OWN_D);
    assign if_rdata  = if_rvalid ? ram_dout : if_hold;
    assign d_rdata   = d_rvalid ? ram_dout : d_hold;

`ifdef RVJ1_ARB_RR_EN
    assign wait_sat = 1'b0;
`else
    logic [3:0] wait_cnt;

    assign wait_sat = (wait_cnt == 4'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            wait_cnt <= '0;
        end else if (d_gnt && !wait_sat) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= OWN_NONE;
            rr_d    <= 1'b1;
            addr_q  <= '0;
            if_hold <= '0;
            d_hold  <= '0;
        end else begin
            owner <= d_gnt  ? OWN_D :
                     if_gnt ? OWN_IF : OWN_NONE;
            if (d_gnt || if_gnt) begin
                addr_q <= ram_addr;
                rr_d   <= d_gnt;
            end
            if (owner == OWN_IF) begin
                if_hold <= ram_dout;
            end
            if (owner == OWN_D) begin
                d_hold <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_rvj1_ram_arbiter.sv
// Scoreboard bench for rvj1_ram_arbiter with a behavioural RAM and reference model.
// Define RVJ1_ARB_RR_EN to check the round-robin build.
module tb_rvj1_ram_arbiter;
    import rvj1_mem_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_dout;

    rvj1_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read-old within a cycle.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_di;
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          if_q[$];
    exp_t          d_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            denied = 0;
    bit            last_d = 1'b1;
    bit            addr_known = 1'b0;
    logic [AW-1:0] last_addr;
    bit            got_i, got_d;
    bit            mon_en = 1'b0;
    bit            have_if = 1'b0, have_d = 1'b0;
    logic [DW-1:0] last_if, last_dd;
    bit            ei_m, ed_m;
    int            if_wins;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference: decide winner from the arbitration rules, predict RAM drive.
    task automatic model_cycle();
        bit ei, ed;
        exp_t e;
        ei = 1'b0;
        ed = 1'b0;
        if (rst) begin
            chk("if_gnt_rst", {31'd0, if_gnt}, 32'd0);
            chk("d_gnt_rst", {31'd0, d_gnt}, 32'd0);
            chk("ram_we_rst", {31'd0, ram_we}, 32'd0);
            got_i = 1'b0;
            got_d = 1'b0;
            return;
        end
        if (if_req && d_req) begin
`ifdef RVJ1_ARB_RR_EN
            ei = last_d;
`else
            ei = (denied == MW);
`endif
            ed = !ei;
        end else begin
            ei = if_req;
            ed = d_req;
        end
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, ei});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
        chk("ram_we", {31'd0, ram_we}, {31'd0, ed && d_we});
        if (ed) begin
            chk("ram_addr_d", {28'd0, ram_addr}, {28'd0, d_addr});
            if (d_we) chk("ram_di", ram_di, d_wdata);
            e.due = cyc + 1;
            e.data = ref_mem[d_addr];
            d_q.push_back(e);
            if (d_we) ref_mem[d_addr] = d_wdata;
            last_addr = d_addr;
            addr_known = 1'b1;
        end else if (ei) begin
            chk("ram_addr_if", {28'd0, ram_addr}, {28'd0, if_addr});
            e.due = cyc + 1;
            e.data = ref_mem[if_addr];
            if_q.push_back(e);
            last_addr = if_addr;
            addr_known = 1'b1;
        end else if (addr_known) begin
            chk("ram_addr_hold", {28'd0, ram_addr}, {28'd0, last_addr});
        end
`ifdef RVJ1_ARB_RR_EN
        if (ei || ed) last_d = ed;
`else
        if (!if_req || ei) denied = 0;
        else if (ed && denied < MW) denied++;
`endif
        got_i = ei;
        got_d = ed;
    endtask

    // Monitor: response due this cycle must appear, nothing else may.
    always @(negedge clk) begin
        if (mon_en) begin
            ei_m = (if_q.size() > 0) && (if_q[0].due == cyc);
            ed_m = (d_q.size() > 0) && (d_q[0].due == cyc);
            chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, ei_m});
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, ed_m});
            if (ei_m) begin
                chk("if_rdata", if_rdata, if_q[0].data);
                last_if = if_q[0].data;
                have_if = 1'b1;
                void'(if_q.pop_front());
            end else if (have_if) begin
                chk("if_rdata_hold", if_rdata, last_if);
            end
            if (ed_m) begin
                chk("d_rdata", d_rdata, d_q[0].data);
                last_dd = d_q[0].data;
                have_d = 1'b1;
                void'(d_q.pop_front());
            end else if (have_d) begin
                chk("d_rdata_hold", d_rdata, last_dd);
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic no_req();
        if_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        no_req();
        if_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'hA500_0000 + 32'(i * 17);
            ref_mem[i] = mem[i];
        end
        mem[15] = 32'hFFFF_FFFF;
        ref_mem[15] = 32'hFFFF_FFFF;
        #1 rst = 1'b1;
        mon_en = 1'b1;
        if_req = 1'b1;
        d_req = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Contention from a fresh reset
        if_addr = 4'd1;
        d_addr = 4'd2;
        d_we = 1'b0;
        if_wins = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_gnt) if_wins++;
            model_cycle();
            @(posedge clk);
            #1;
        end
`ifdef RVJ1_ARB_RR_EN
        chk("contention_if_wins", 32'(if_wins), 32'd4);
`else
        chk("contention_if_wins", 32'(if_wins), 32'd2);
`endif
        no_req();
        cycle();

        // Fetch only
        if_req = 1'b1;
        if_addr = 4'd5;
        repeat (3) cycle();
        no_req();
        cycle();

        // Write then read same address
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 4'd3;
        d_wdata = 32'hDEAD_BEEF;
        cycle();
        d_we = 1'b0;
        cycle();
        no_req();
        cycle();
        chk("mem3_ref", ref_mem[3], 32'hDEAD_BEEF);

        // Idle, then read back the untouched top word
        repeat (4) cycle();
        if_req = 1'b1;
        if_addr = 4'd15;
        cycle();
        no_req();
        cycle();

        // Reset in the middle of an access
        if_req = 1'b1;
        if_addr = 4'd7;
        @(negedge clk);
        model_cycle();
        #1 rst = 1'b1;
        if_q.delete();
        d_q.delete();
        have_if = 1'b0;
        have_d = 1'b0;
        denied = 0;
        last_d = 1'b1;
        addr_known = 1'b0;
        #1;
        chk("if_rvalid_rst_now", {31'd0, if_rvalid}, 32'd0);
        chk("d_rvalid_rst_now", {31'd0, d_rvalid}, 32'd0);
        d_req = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        no_req();
        repeat (3) cycle();
        if_req = 1'b1;
        cycle();
        no_req();
        cycle();

        // Randomized traffic, requests held until granted
        for (int i = 0; i < 400; i++) begin
            if (!if_req || got_i) begin
                if_req = ($urandom_range(0, 3) != 0);
                if_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            if (!d_req || got_d) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, DEPTH - 1));
                d_wdata = $urandom();
            end
            cycle();
        end
        no_req();
        repeat (3) cycle();
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("d_q_drained", 32'(d_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
